poly_sub_ctrl: RTL and testbench

- Sequencer that computes c[i] = (a[i] - b[i]) mod Q for every coefficient of one Kyber polynomial, i = 0..N-1.
- Reads operands from two coefficient RAMs with 1-cycle read latency, passes each pair through one instantiated modsub unit, registers the result and writes it to a result RAM.
- Sits between the top-level polynomial scheduler (start/done handshake) and the coefficient memories.

---
 rtl/poly_sub_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_poly_sub_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/poly_sub_ctrl.sv
// ---------------------------------------------------------------------------
// poly_sub_ctrl : coefficient-wise modular subtraction sequencer.
//
// Computes c[i] = (a[i] - b[i]) mod Q_VALUE for i = 0..N-1 of one polynomial.
// Operands come from two RAMs with 1-cycle read latency through a shared
// read address. Each pair goes through one modsub unit, the result is
// registered and written to the result RAM two cycles after the read.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   request one polynomial pass (sampled in IDLE only)
//   hold     in   suppresses issue of new reads while high
//   busy     out  high from the cycle after start is accepted until done
//   done     out  one-cycle pulse after the last write has been issued
//   rd_en    out  read strobe to both operand RAMs
//   rd_addr  out  shared operand read address
//   a_rdata  in   operand a, valid the cycle after rd_en
//   b_rdata  in   operand b, valid the cycle after rd_en
//   wr_en    out  result write strobe
//   wr_addr  out  result address
//   wr_data  out  result coefficient
//   err      out  operand range flag
//
// Optional feature macro: POLY_SUB_RANGE_CHK_EN
//   defined   : err is set when a stage-1 operand is >= Q_VALUE; sticky
//               until the next accepted start or reset.
//   undefined : no range comparators, err tied low.
// ---------------------------------------------------------------------------

// Combinational modular subtractor: res = (a - b) mod q for a, b in [0, q).
module modsub #(
  parameter int LOGQ    = 12,
  parameter int Q_VALUE = 3329
) (
  input  logic [LOGQ-1:0] a,
  input  logic [LOGQ-1:0] b,
  output logic [LOGQ-1:0] res
);

  localparam logic [LOGQ-1:0] Q_L = LOGQ'(Q_VALUE);

  logic [LOGQ:0] diff_s;

  // Subtract with one extra sign bit; a negative difference is corrected by
  // adding q, and the LOGQ-bit addition drops the carry out as intended.
  always_comb begin
    diff_s = {1'b0, a} - {1'b0, b};
    if (diff_s[LOGQ]) begin
      res = diff_s[LOGQ-1:0] + Q_L;
    end else begin
      res = diff_s[LOGQ-1:0];
    end
  end

endmodule

module poly_sub_ctrl #(
  parameter int LOGQ    = 12,
  parameter int Q_VALUE = 3329,
  parameter int N       = 256,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [LOGQ-1:0]   a_rdata,
  input  logic [LOGQ-1:0]   b_rdata,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [LOGQ-1:0]   wr_data,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_nx_s;
  logic              issue_s;
  logic              start_acc_s;
  logic [ADDR_W-1:0] cnt_r;
  logic              v1_r;
  logic [ADDR_W-1:0] a1_r;
  logic              v2_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [LOGQ-1:0]   wr_data_r;
  logic              busy_r;
  logic              done_r;
  logic [LOGQ-1:0]   sub_res_s;

  // Next-state and read-issue decode.
  always_comb begin
    state_nx_s  = state_r;
    issue_s     = 1'b0;
    start_acc_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          start_acc_s = 1'b1;
          state_nx_s  = ISSUE;
        end else begin
          state_nx_s  = IDLE;
        end
      end
      ISSUE: begin
        if (!hold) begin
          issue_s = 1'b1;
          if (cnt_r == LAST_ADDR) begin
            state_nx_s = DRAIN;
          end else begin
            state_nx_s = ISSUE;
          end
        end else begin
          state_nx_s = ISSUE;
        end
      end
      DRAIN: begin
        // Leave only once both pipeline stages have emptied.
        if (!v1_r && !v2_r) begin
          state_nx_s = FIN;
        end else begin
          state_nx_s = DRAIN;
        end
      end
      FIN: begin
        // start seen here is deliberately dropped, not queued.
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // busy/done are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_nx_s == ISSUE) || (state_nx_s == DRAIN);
      done_r <= (state_nx_s == FIN);
    end
  end

  // Issue counter: cleared on start, saturates at the last address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (start_acc_s) begin
      cnt_r <= '0;
    end else if (issue_s && (cnt_r != LAST_ADDR)) begin
      cnt_r <= cnt_r + ADDR_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Stage 1: remember which address the returning read data belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r <= 1'b0;
      a1_r <= '0;
    end else begin
      v1_r <= issue_s;
      if (issue_s) begin
        a1_r <= cnt_r;
      end else begin
        a1_r <= a1_r;
      end
    end
  end

  modsub #(
    .LOGQ    (LOGQ),
    .Q_VALUE (Q_VALUE)
  ) u_modsub (
    .a   (a_rdata),
    .b   (b_rdata),
    .res (sub_res_s)
  );

  // Stage 2: register the result; address/data hold while no entry is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_r      <= 1'b0;
      wr_addr_r <= '0;
      wr_data_r <= '0;
    end else begin
      v2_r <= v1_r;
      if (v1_r) begin
        wr_addr_r <= a1_r;
        wr_data_r <= sub_res_s;
      end else begin
        wr_addr_r <= wr_addr_r;
        wr_data_r <= wr_data_r;
      end
    end
  end

`ifdef POLY_SUB_RANGE_CHK_EN
  localparam logic [LOGQ-1:0] Q_L = LOGQ'(Q_VALUE);

  logic err_r;

  // Sticky range flag, cleared when the next pass is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (start_acc_s) begin
      err_r <= 1'b0;
    end else if (v1_r && ((a_rdata >= Q_L) || (b_rdata >= Q_L))) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  // rd_en follows hold within the same cycle, so it is decoded from the
  // registered state rather than registered itself.
  assign rd_en   = issue_s;
  assign rd_addr = cnt_r;
  assign wr_en   = v2_r;
  assign wr_addr = wr_addr_r;
  assign wr_data = wr_data_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: tb/tb_poly_sub_ctrl.sv
// Scoreboard bench for poly_sub_ctrl: expected writes are queued when a pass
// is started and a monitor pops/compares on every wr_en.
module tb_poly_sub_ctrl;

  localparam int N    = 256;
  localparam int LOGQ = 12;
  localparam int Q    = 3329;
  localparam int AW   = 8;
`ifdef POLY_SUB_RANGE_CHK_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            hold = 1'b0;
  logic            busy, done, rd_en, wr_en, err;
  logic [AW-1:0]   rd_addr, wr_addr;
  logic [LOGQ-1:0] a_rdata = '0;
  logic [LOGQ-1:0] b_rdata = '0;
  logic [LOGQ-1:0] wr_data;

  logic [LOGQ-1:0] a_mem [N];
  logic [LOGQ-1:0] b_mem [N];
  int              exp_c [N];

  typedef struct {
    int addr;
    int data;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_wr  = 0;

  poly_sub_ctrl #(.LOGQ(LOGQ), .Q_VALUE(Q), .N(N), .ADDR_W(AW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .hold    (hold),
    .busy    (busy),
    .done    (done),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .a_rdata (a_rdata),
    .b_rdata (b_rdata),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Operand RAMs, one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en) begin
      a_rdata <= a_mem[rd_addr];
      b_rdata <= b_mem[rd_addr];
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      n_wr++;
      check("wr_expected", int'(sbq.size() > 0), 1);
      if (sbq.size() > 0) begin
        mon_e = sbq.pop_front();
        check("wr_addr", int'(wr_addr), mon_e.addr);
        check("wr_data", int'(wr_data), mon_e.data);
      end
    end
  end

  // Out-of-contract aware reference: a-b, +Q if negative, kept to LOGQ bits.
  function automatic int ref_sub(input int a, input int b);
    int d;
    d = a - b;
    if (d < 0) d = d + Q;
    return d % (1 << LOGQ);
  endfunction

  // One pass; cycle 0 is the cycle start is high. Optional hold window,
  // extra start pulses, reset injection and err timing checks.
  task automatic run_pass(input string tag, input int hold_from, input int hold_len,
                          input int restart_at, input bit fin_start, input int rst_at,
                          input int exp_done, input int err_cyc);
    int done_cnt = 0;
    int done_at  = -1;
    int wr0;
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.addr = i;
      e.data = exp_c[i];
      sbq.push_back(e);
    end
    wr0 = n_wr;
    @(negedge clk);
    start = 1'b1;
    for (int t = 1; t <= exp_done + 12; t++) begin
      @(negedge clk);
      if (t == 1) begin
        check({tag, "_busy_c1"}, int'(busy), 1);
        check({tag, "_err_c1"}, int'(err), 0);
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = t;
        check({tag, "_busy_at_done"}, int'(busy), 0);
      end
      if (err_cyc > 0 && t == err_cyc - 1) check({tag, "_err_before"}, int'(err), 0);
      if (err_cyc > 0 && t == err_cyc)     check({tag, "_err_rise"}, int'(err), ERR_EN);
      if (err_cyc > 0 && t == exp_done)    check({tag, "_err_at_done"}, int'(err), ERR_EN);
      if (t == rst_at) begin
        #2;
        rst_n = 1'b0;
        start = 1'b0;
        hold  = 1'b0;
        #1;
        check({tag, "_rst_busy"}, int'(busy), 0);
        check({tag, "_rst_done"}, int'(done), 0);
        check({tag, "_rst_rd_en"}, int'(rd_en), 0);
        check({tag, "_rst_wr_en"}, int'(wr_en), 0);
        check({tag, "_rst_rd_addr"}, int'(rd_addr), 0);
        check({tag, "_rst_wr_addr"}, int'(wr_addr), 0);
        check({tag, "_rst_wr_data"}, int'(wr_data), 0);
        check({tag, "_rst_err"}, int'(err), 0);
        check({tag, "_writes_before_rst"}, n_wr - wr0, rst_at - 2);
        sbq.delete();
        wr0 = n_wr;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check({tag, "_writes_after_rst"}, n_wr - wr0, 0);
        check({tag, "_busy_after_rst"}, int'(busy), 0);
        return;
      end
      start = (t == restart_at) || (fin_start && done);
      hold  = (t >= hold_from) && (t < hold_from + hold_len);
      #1;
      if (hold) check({tag, "_rd_en_in_hold"}, int'(rd_en), 0);
    end
    start = 1'b0;
    hold  = 1'b0;
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_done_cycle"}, done_at, exp_done);
    check({tag, "_write_count"}, n_wr - wr0, N);
    check({tag, "_sb_empty"}, sbq.size(), 0);
    check({tag, "_busy_end"}, int'(busy), 0);
  endtask

  task automatic load_ramp();
    for (int i = 0; i < N; i++) begin
      a_mem[i] = LOGQ'(i);
      b_mem[i] = '0;
      exp_c[i] = i;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rd_en", int'(rd_en), 0);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_rd_addr", int'(rd_addr), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_wr_data", int'(wr_data), 0);
    check("rst_err", int'(err), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // c[i] = i
    load_ramp();
    run_pass("ramp", -1, 0, -1, 1'b0, -1, 260, -1);

    // 0 - 1 wraps to 3328; c[5] = 1000 - 3328 + 3329 = 1001
    for (int i = 0; i < N; i++) begin
      a_mem[i] = '0;
      b_mem[i] = 12'd1;
      exp_c[i] = 3328;
    end
    a_mem[5] = 12'd1000;
    b_mem[5] = 12'd3328;
    exp_c[5] = 1001;
    run_pass("wrap", -1, 0, -1, 1'b0, -1, 260, -1);

    // Mixed operand patterns across the whole range.
    for (int i = 0; i < N; i++) begin
      a_mem[i] = LOGQ'((i * 37 + 11) % Q);
      b_mem[i] = LOGQ'((i * 1201 + 3000) % Q);
      exp_c[i] = ref_sub((i * 37 + 11) % Q, (i * 1201 + 3000) % Q);
    end
    a_mem[0] = 12'd3328; b_mem[0] = 12'd0;    exp_c[0] = 3328;
    a_mem[1] = 12'd0;    b_mem[1] = 12'd3328; exp_c[1] = 1;
    a_mem[2] = 12'd1234; b_mem[2] = 12'd1234; exp_c[2] = 0;
    run_pass("mix", -1, 0, -1, 1'b0, -1, 260, -1);

    // Same data with hold in cycles 10..19: done 10 cycles later.
    run_pass("hold", 10, 10, -1, 1'b0, -1, 270, -1);

    // Start re-pulsed at cycle 50 and in the FIN cycle: ignored.
    load_ramp();
    run_pass("restart", -1, 0, 50, 1'b1, -1, 260, -1);

    // Reset in cycle 100 abandons the pass.
    run_pass("reset", -1, 0, -1, 1'b0, 100, 260, -1);
    repeat (2) @(negedge clk);

    // Out-of-range operand at address 7; 3329 - 0 is written uncorrected.
    load_ramp();
    a_mem[7] = 12'd3329;
    exp_c[7] = 3329;
    run_pass("range", -1, 0, -1, 1'b0, -1, 260, 10);
    repeat (3) @(negedge clk);
    check("err_sticky_idle", int'(err), ERR_EN);

    // Next accepted start clears err (checked in cycle 1 of the pass).
    load_ramp();
    run_pass("after_err", -1, 0, -1, 1'b0, -1, 260, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
